uart_rx_controller: RTL and testbench

UART receive controller; the counterpart to the team's UART transmit controller. It recovers 8-bit frames from a serial line using a fixed clocks-per-bit count: one start bit (0), 8 data bits LSB-first, an optional parity bit, and one stop bit (1). It sits between the asynchronous RX pin and the byte-level consumer. It presents each received byte with a one-cycle valid pulse and flags framing and parity errors.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync2.sv | 31 +++
 rtl/uart_rx_controller.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the 3-bit state encoding used by the
// receive and transmit controllers.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_ST_W   = 3;

  typedef enum logic [UART_ST_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to RST_VAL.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_controller.sv
// UART receiver: start, 8 data bits LSB-first, optional even parity, one stop bit.
// Define UART_RX_PARITY_EN to compile in the parity bit and o_parity_err.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_rx_serial,
  output logic [UART_DATA_W-1:0] o_rx_data,
  output logic                   o_rx_valid,
  output logic                   o_rx_active,
  output logic                   o_frame_err,
  output logic                   o_parity_err
);

  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (i_rx_serial),
    .q     (rx_s)
  );

  uart_state_e            state_d, state_q;
  logic [CW-1:0]          cnt_d, cnt_q;
  logic [2:0]             idx_d, idx_q;
  logic [UART_DATA_W-1:0] shreg_d, shreg_q;
  logic [UART_DATA_W-1:0] data_d, data_q;
  logic                   valid_d, valid_q;
  logic                   active_d, active_q;
  logic                   ferr_d, ferr_q;
`ifdef UART_RX_PARITY_EN
  logic                   par_d, par_q;
  logic                   perr_d, perr_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    active_d = active_q;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
    perr_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
        if (!rx_s) begin
          active_d = 1'b1;
          // The detection cycle counts as the first cycle of the half-bit wait,
          // so with a zero half-bit the start bit is already confirmed here.
          if (HALF == 0) begin
            state_d = DATA;
          end else begin
            state_d = START;
            cnt_d   = CW'(1);
          end
        end
      end
      START: begin
        if (cnt_q == HALF_C) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
          end else begin
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          if (&idx_q) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        // Deciding mid-stop-bit lets IDLE catch a start bit that follows at once.
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d   = shreg_q;
            valid_d  = 1'b1;
            active_d = 1'b0;
            state_d  = IDLE;
`ifdef UART_RX_PARITY_EN
            perr_d   = ^{shreg_q, par_q};
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d  = IDLE;
          active_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      ferr_q   <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_rx_data   = data_q;
  assign o_rx_valid  = valid_q;
  assign o_rx_active = active_q;
  assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: three instances (1, 4 and 16 clocks per bit),
// directed and random frames checked against a frame-level event model.
module tb_uart_rx_controller;

`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct {
    int         lane;
    int         cyc;
    logic [1:0] kind;   // {valid, frame_err}
    logic [7:0] data;
    logic       perr;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] rx_line = 3'b111;
  logic [7:0] rx_data [3];
  logic [2:0] rx_valid, rx_active, ferr, perr;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  ev_t  mon_e;
  logic [7:0] last_good [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_controller #(.CLKS_PER_BIT(1)) u_dut0 (
    .clk(clk), .reset(reset), .i_rx_serial(rx_line[0]), .o_rx_data(rx_data[0]),
    .o_rx_valid(rx_valid[0]), .o_rx_active(rx_active[0]), .o_frame_err(ferr[0]),
    .o_parity_err(perr[0]));
  uart_rx_controller #(.CLKS_PER_BIT(4)) u_dut1 (
    .clk(clk), .reset(reset), .i_rx_serial(rx_line[1]), .o_rx_data(rx_data[1]),
    .o_rx_valid(rx_valid[1]), .o_rx_active(rx_active[1]), .o_frame_err(ferr[1]),
    .o_parity_err(perr[1]));
  uart_rx_controller #(.CLKS_PER_BIT(16)) u_dut2 (
    .clk(clk), .reset(reset), .i_rx_serial(rx_line[2]), .o_rx_data(rx_data[2]),
    .o_rx_valid(rx_valid[2]), .o_rx_active(rx_active[2]), .o_frame_err(ferr[2]),
    .o_parity_err(perr[2]));

  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (rx_valid[l] || ferr[l]) begin
        mon_e.lane = l;
        mon_e.cyc  = cyc;
        mon_e.kind = {rx_valid[l], ferr[l]};
        mon_e.data = rx_data[l];
        mon_e.perr = perr[l];
        obs_q.push_back(mon_e);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int cpb_of(input int l);
    return (l == 0) ? 1 : (l == 1) ? 4 : 16;
  endfunction

  task automatic drive(input int l, input logic lvl, input int n);
    rx_line[l] = lvl;
    repeat (n) @(negedge clk);
  endtask

  // Expected outcome is fixed at send time: one event, HALF + 2 cycles past
  // the nominal start of the stop bit, measured from the first capture edge.
  task automatic send_frame(input int l, input logic [7:0] b, input logic pbit,
                            input logic stop, input int hold_low, input int gap);
    int  cpb;
    int  t0;
    ev_t e;
    cpb    = cpb_of(l);
    t0     = cyc + 1;
    e.lane = l;
    e.cyc  = t0 + 2 + (cpb - 1) / 2 + (9 + P) * cpb;
    if (stop) begin
      e.kind = 2'b10;
      e.data = b;
      e.perr = (P == 1) && (($countones({b, pbit}) % 2) == 1);
      last_good[l] = b;
    end else begin
      e.kind = 2'b01;
      e.data = 8'h00;
      e.perr = 1'b0;
    end
    exp_q.push_back(e);
    drive(l, 1'b0, cpb);
    for (int k = 0; k < 8; k++) drive(l, b[k], cpb);
    if (P == 1) drive(l, pbit, cpb);
    drive(l, stop, cpb);
    if (!stop) drive(l, 1'b0, hold_low);
    rx_line[l] = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic flush(input string tag);
    repeat (6) @(negedge clk);
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_eq({tag, "_lane"}, obs_q[i].lane, exp_q[i].lane);
      check_eq({tag, "_cyc"},  obs_q[i].cyc,  exp_q[i].cyc);
      check_eq({tag, "_kind"}, {30'd0, obs_q[i].kind}, {30'd0, exp_q[i].kind});
      if (exp_q[i].kind == 2'b10)
        check_eq({tag, "_data"}, {24'd0, obs_q[i].data}, {24'd0, exp_q[i].data});
      check_eq({tag, "_perr"}, {31'd0, obs_q[i].perr}, {31'd0, exp_q[i].perr});
    end
    for (int l = 0; l < 3; l++)
      check_eq({tag, "_hold_data"}, {24'd0, rx_data[l]}, {24'd0, last_good[l]});
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_flags"}, {20'd0, rx_valid, rx_active, ferr, perr}, 32'd0);
    for (int l = 0; l < 3; l++)
      check_eq({tag, "_data"}, {24'd0, rx_data[l]}, 32'd0);
  endtask

  initial begin
    int t0;
    int c;
    logic [7:0] b;
    logic       stp;
    for (int l = 0; l < 3; l++) last_good[l] = 8'h00;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("post_reset");

    // Good byte at 4 clocks/bit: valid registered at T0+39 (+4 with parity).
    send_frame(1, 8'hA5, 1'b0, 1'b1, 0, 4);
    flush("good_a5");

    // Start glitch at 16 clocks/bit: three low cycles, then high.
    t0 = cyc + 1;
    rx_line[2] = 1'b0;
    while (cyc < t0 + 12) begin
      @(negedge clk);
      if (cyc == t0 + 1) check_eq("glitch_act_t1", rx_active[2], 1'b0);
      if (cyc == t0 + 2) begin
        check_eq("glitch_act_t2", rx_active[2], 1'b1);
        rx_line[2] = 1'b1;
      end
      if (cyc == t0 + 8) check_eq("glitch_act_t8", rx_active[2], 1'b1);
      if (cyc == t0 + 9) check_eq("glitch_act_t9", rx_active[2], 1'b0);
    end
    flush("glitch");

    // Framing error with the line held low after the stop bit.
    send_frame(1, 8'h3C, 1'b0, 1'b0, 40, 0);
    c = cyc;
    check_eq("break_act_low", rx_active[1], 1'b1);
    while (cyc < c + 3) begin
      @(negedge clk);
      if (cyc == c + 2) check_eq("break_act_h1", rx_active[1], 1'b1);
      if (cyc == c + 3) check_eq("break_act_h2", rx_active[1], 1'b0);
    end
    flush("frame_err");

    // Back-to-back at one clock per bit.
    send_frame(0, 8'h00, 1'b0, 1'b1, 0, 0);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 0, 0);
    send_frame(0, 8'h81, 1'b0, 1'b1, 0, 3);
    flush("b2b");

    // Parity bit 1 then 0 on 0x07 (three ones: 1 is correct even parity).
    send_frame(1, 8'h07, 1'b1, 1'b1, 0, 2);
    send_frame(1, 8'h07, 1'b0, 1'b1, 0, 2);
    flush("parity");

    for (int l = 0; l < 3; l++) begin
      for (int n = 0; n < ((l == 2) ? 4 : 20); n++) begin
        b   = 8'($urandom);
        stp = ($urandom_range(0, 5) != 0);
        if (stp)
          send_frame(l, b, 1'($urandom), 1'b1, 0, $urandom_range(0, 4));
        else
          send_frame(l, b, 1'($urandom), 1'b0, $urandom_range(0, 20), $urandom_range(2, 5));
      end
      flush("random");
    end

    // Reset in the middle of data bit 4, then a clean 0x5A.
    b = 8'h5A;
    drive(1, 1'b0, 4);
    for (int k = 0; k < 4; k++) drive(1, b[k], 4);
    drive(1, b[4], 2);
    reset = 1'b0;
    rx_line[1] = 1'b1;
    for (int l = 0; l < 3; l++) last_good[l] = 8'h00;
    @(negedge clk);
    check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("after_mid_reset");
    send_frame(1, 8'h5A, 1'b0, 1'b1, 0, 2);
    flush("post_reset_5a");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
